// File: rtl/pc_next_if.sv
// Fetch-side bundle between the CPU datapath/control and the program counter unit.
// The CPU control drives the select and data inputs; the PC unit returns fetch address and status.
interface pc_next_if #(
  parameter int CNT_W = 8
);
  logic [15:0]      Shift_Jump_out;
  logic [11:0]      Jump_Index;
  logic [15:0]      Jump_Reg_Addr;
  logic             Branch;
  logic             Zero;
  logic             Jump;
  logic             Jump_Reg;
  logic             Stall;
  logic             Halt;
  logic [15:0]      PC;
  logic [15:0]      PC_Plus_2;
  logic             PC_Valid;
  logic             Halted;
  logic             Misaligned;
  logic [CNT_W-1:0] Redirect_Count;

  modport master (
    output Shift_Jump_out, Jump_Index, Jump_Reg_Addr, Branch, Zero, Jump, Jump_Reg, Stall, Halt,
    input  PC, PC_Plus_2, PC_Valid, Halted, Misaligned, Redirect_Count
  );

  modport slave (
    input  Shift_Jump_out, Jump_Index, Jump_Reg_Addr, Branch, Zero, Jump, Jump_Reg, Stall, Halt,
    output PC, PC_Plus_2, PC_Valid, Halted, Misaligned, Redirect_Count
  );
endinterface

// File: rtl/pc_next_unit.sv
// Program counter and next-PC selection for the 16-bit single-cycle CPU, with a
// START/RUN/HALTED run-state machine so the first fetch after reset is clean.
module pc_next_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int          CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  pc_next_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t           state_q;
  logic [15:0]      pc_q;
  logic [15:0]      pc_d;
  logic             pc_valid_q;
  logic             halted_q;
  logic             misaligned_q;
  logic [CNT_W-1:0] redirect_cnt_q;

  logic [15:0]      pc_plus_2;
  logic             redirect;
  logic             misalign_hit;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pc_plus_2    = pc_q + 16'd2;
    pc_d         = pc_plus_2;
    redirect     = 1'b0;
    misalign_hit = 1'b0;
    if (bus.Jump_Reg) begin
      pc_d         = {bus.Jump_Reg_Addr[15:1], 1'b0};
      redirect     = 1'b1;
      misalign_hit = bus.Jump_Reg_Addr[0];
    end else if (bus.Jump) begin
      pc_d     = {pc_plus_2[15:13], bus.Jump_Index, 1'b0};
      redirect = 1'b1;
    end else if (bus.Branch && bus.Zero) begin
      pc_d     = pc_plus_2 + bus.Shift_Jump_out;
      redirect = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_START;
      pc_q           <= RESET_VECTOR;
      pc_valid_q     <= 1'b0;
      halted_q       <= 1'b0;
      misaligned_q   <= 1'b0;
      redirect_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_START: begin
          // Halt is deliberately ignored here: the first RUN cycle always fetches the reset vector.
          state_q    <= ST_RUN;
          pc_valid_q <= 1'b1;
        end
        ST_RUN: begin
          if (bus.Halt) begin
            state_q    <= ST_HALTED;
            pc_valid_q <= 1'b0;
            halted_q   <= 1'b1;
          end else if (!bus.Stall) begin
            pc_q         <= pc_d;
            misaligned_q <= misaligned_q | misalign_hit;
            if (redirect && (redirect_cnt_q != '1)) begin
              redirect_cnt_q <= redirect_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_HALTED: begin
          state_q <= ST_HALTED;
        end
        default: begin
          state_q    <= ST_START;
          pc_valid_q <= 1'b0;
          halted_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PC             = pc_q;
  assign bus.PC_Plus_2      = pc_plus_2;
  assign bus.PC_Valid       = pc_valid_q;
  assign bus.Halted         = halted_q;
  assign bus.Misaligned     = misaligned_q;
  assign bus.Redirect_Count = redirect_cnt_q;

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Program-counter register and next-PC selector for the 16-bit single-cycle CPU.
- Consumes the word-to-byte shifted branch offset (Shift_Jump_out, already shifted left by 1).
- Produces the fetch address and PC+2 each cycle, and selects among:
  - sequential PC+2;
  - PC-relative branch;
  - pseudo-direct jump;
  - register jump.
- Provides stall/halt control and a small run-state machine, so instruction memory sees a clean first fetch after reset.

Parameters:
- RESET_VECTOR, 16'h0000, PC value loaded on reset; must be even.
- CNT_W, 8, width of the taken-branch/jump event counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- Shift_Jump_out  input  16  sign-extended branch offset, already shifted left 1 (byte offset).
- Jump_Index  input  12  jump immediate in words.
- Jump_Reg_Addr  input  16  register-jump target.
- Branch  input  1  current instruction is a conditional branch.
- Zero  input  1  ALU zero flag; branch is taken when Branch&Zero.
- Jump  input  1  pseudo-direct jump.
- Jump_Reg  input  1  register jump.
- Stall  input  1  hold PC this cycle.
- Halt  input  1  enter HALTED permanently until reset.
- PC  output  16  current fetch address.
- PC_Plus_2  output  16  PC+2, combinational from PC.
- PC_Valid  output  1  fetch address valid (RUN state only).
- Halted  output  1  high in HALTED state.
- Misaligned  output  1  sticky: a register-jump target had bit0=1.
- Redirect_Count  output  CNT_W  number of taken branches plus jumps since reset, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous), effective immediately and also mid-operation:
  - PC=RESET_VECTOR, state=START, Misaligned=0, Redirect_Count=0.
  - PC_Valid=0, Halted=0.
- States:
  - START: one cycle after reset release; PC held, PC_Valid=0; next state RUN unconditionally (Halt ignored here).
  - RUN: PC_Valid=1; PC updates every clk unless Stall; Halt=1 -> HALTED at the next edge, with the PC update of that cycle suppressed.
  - HALTED: PC frozen, PC_Valid=0, Halted=1; leaves only via reset.
- Arithmetic, all mod 2^16, carries dropped:
  - PC_Plus_2 = PC+2 (16'hFFFE -> 16'h0000).
  - Branch target = PC_Plus_2 + Shift_Jump_out; a negative offset wraps naturally.
  - Jump target = {PC_Plus_2[15:13], Jump_Index, 1'b0}.
  - Register-jump target = {Jump_Reg_Addr[15:1], 1'b0}. If Jump_Reg_Addr[0]=1, set Misaligned at that same edge; it stays set until reset.
- Next-PC priority in RUN, evaluated at each rising edge:
  - Halt > Stall > Jump_Reg > Jump > (Branch & Zero) > PC_Plus_2.
  - Stall=1: PC, Misaligned and Redirect_Count all unchanged; all other inputs ignored.
  - Jump and Jump_Reg both high: Jump_Reg wins.
  - Branch with Zero=0 behaves as sequential.
- Redirect_Count increments by 1 on each RUN edge where Jump_Reg, Jump or (Branch&Zero) is selected and neither Stall nor Halt is high. It saturates at all-ones.
- Latency:
  - Select inputs affect PC exactly one edge later.
  - PC_Plus_2 is valid in the same cycle as PC.
- No state change in START or HALTED besides the transitions listed above.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> PC=16'h0000 immediately, PC_Valid=0; release -> one START cycle with PC_Valid=0, then RUN; PC steps 0000,0002,0004.
- Branch: PC=16'h0010, Branch=1, Zero=1, Shift_Jump_out=16'hFFFC -> next PC=16'h000E, Redirect_Count+1. Same stimulus with Zero=0 -> PC=16'h0012, count unchanged.
- Wrap: PC=16'hFFFE sequential -> next PC=16'h0000. PC=16'hFFF0 branch with Shift_Jump_out=16'h0020 -> next PC=16'h0012.
- Jump: PC=16'h4000, Jump=1, Jump_Index=12'h0AB -> next PC=16'h4156. Same cycle with Jump_Reg=1, Jump_Reg_Addr=16'h1235 -> next PC=16'h1234, Misaligned=1 and stays 1.
- Stall/Halt: Stall=1 with Jump=1 for 3 cycles -> PC and count frozen. Halt=1 -> Halted=1, PC_Valid=0, PC frozen despite Branch&Zero; only rst_n=0 recovers.
- Saturation: CNT_W=2, 5 taken branches -> Redirect_Count=2'b11.
